// File: rtl/veririsc_pkg.sv
// Shared definitions for the VeriRISC fetch sequencer.
// Contents: opcode constants, phase encodings and the ALU-class opcode decode.
package veririsc_pkg;

  // Opcodes (IR[7:5]).
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // One instruction is one pass through these eight phases.
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter for the VeriRISC sequencer.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high clear
//   inc      increment on the next edge (modulo 2^ADDR_WIDTH)
//   load     load load_val on the next edge; wins over inc
//   load_val jump target
//   pc       current program counter
module prog_counter #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_val,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else if (load) begin
      pc_q <= load_val;
    end else if (inc) begin
      pc_q <= pc_q + ADDR_WIDTH'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// VeriRISC instruction sequencer: runs the 8-phase fetch/execute cycle, holds IR and PC,
// muxes PC or IR operand onto the memory address and decodes the datapath strobes.
// Optional feature: define SINGLE_STEP_EN to add the `step` input; the sequencer then
// waits in phase 0 until step is sampled high and runs one instruction per step.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   step         (SINGLE_STEP_EN only) release one instruction from phase 0
//   mem_data_in  memory read data
//   ac_zero      accumulator-is-zero flag, used by SKZ in ALU_OP
//   mem_addr     PC in phases 0-3, IR operand in phases 4-7
//   mem_rd       memory read strobe
//   mem_wr       memory write strobe (STO, phase 7)
//   data_oe      accumulator drive enable (STO, phases 6-7)
//   ld_ac        accumulator load strobe (ALU opcodes, phase 7)
//   opcode       current IR opcode
//   phase        current phase 0..7
//   halt         sticky halt indicator
module fetch_sequencer
  import veririsc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SINGLE_STEP_EN
  input  logic                    step,
`endif
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic                    ac_zero,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    data_oe,
  output logic                    ld_ac,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [2:0]              phase,
  output logic                    halt
);

  if ((DATA_WIDTH != OPCODE_WIDTH + ADDR_WIDTH) || (OPCODE_WIDTH != 3)) begin : gen_bad_cfg
    $error("fetch_sequencer: need OPCODE_WIDTH==3 and DATA_WIDTH==OPCODE_WIDTH+ADDR_WIDTH");
  end

  phase_e                phase_q, phase_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  halted_q, halted_d;
  logic                  pc_inc, pc_load;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] operand;
  logic [2:0]            op;
  logic                  go;
  logic                  alu, sto;

  assign operand = ir_q[ADDR_WIDTH-1:0];
  assign opcode  = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign op      = 3'(opcode);
  assign alu     = is_aluop(op);
  assign sto     = (op == STO);

`ifdef SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  prog_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prog_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (operand),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Next state: once halted everything freezes until reset.
  always_comb begin
    phase_d  = phase_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    if (!halted_q) begin
      phase_d = phase_e'(phase_q + 3'd1);
      unique case (phase_q)
        INST_ADDR: begin
          if (!go) phase_d = INST_ADDR;
        end
        // IR is captured twice; the second load just re-reads the same word.
        INST_LOAD, IDLE: ir_d = mem_data_in;
        OP_ADDR: begin
          if (op == HLT) begin
            halted_d = 1'b1;
            phase_d  = OP_ADDR;
          end else begin
            pc_inc = 1'b1;
          end
        end
        ALU_OP: begin
          if (op == JMP) begin
            pc_load = 1'b1;
          end else if ((op == SKZ) && ac_zero) begin
            pc_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes depend only on registered phase/IR, never on inputs.
  always_comb begin
    halt    = halted_q || ((phase_q == OP_ADDR) && (op == HLT));
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    data_oe = 1'b0;
    ld_ac   = 1'b0;
    if (!halt) begin
      unique case (phase_q)
        INST_FETCH, INST_LOAD, IDLE: mem_rd = 1'b1;
        OP_FETCH: mem_rd = alu;
        ALU_OP: begin
          mem_rd  = alu;
          data_oe = sto;
        end
        STORE: begin
          mem_rd  = alu;
          data_oe = sto;
          mem_wr  = sto;
          ld_ac   = alu;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = phase_q[2] ? operand : pc;
  assign phase    = phase_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: behavioural 32x8 memory, instruction-level
// reference model feeding a per-cycle expectation queue, monitor popping on each negedge.
module tb_fetch_sequencer;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef logic [7:0] mem_t[32];

  typedef struct packed {
    logic [2:0] ph;
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic       oe;
    logic       ld;
    logic [2:0] opc;
    logic       hlt;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ac_zero = 1'b0;
  logic [7:0] mem_data_in;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr, data_oe, ld_ac, halt;
  logic [2:0] opcode, phase;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_WIDTH   (5),
    .DATA_WIDTH   (8),
    .OPCODE_WIDTH (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SINGLE_STEP_EN
    .step        (step),
`endif
    .mem_data_in (mem_data_in),
    .ac_zero     (ac_zero),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .data_oe     (data_oe),
    .ld_ac       (ld_ac),
    .opcode      (opcode),
    .phase       (phase),
    .halt        (halt)
  );

  // Environment memory: preload on request, otherwise accept STO writes.
  mem_t       env_mem;
  mem_t       load_img;
  logic       load_req = 1'b0;
  logic [7:0] acc_val = 8'h00;
  int         wr_count = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= load_img[i];
      wr_count <= 0;
    end else if (mem_wr) begin
      env_mem[mem_addr] <= acc_val;
      wr_count <= wr_count + 1;
    end
  end

  assign mem_data_in = env_mem[mem_addr];

  // Reference model state (instruction level).
  mem_t       ref_mem;
  logic [4:0] ref_pc;
  bit         ref_halted;
  logic [2:0] ref_prev_op;
  logic [4:0] ref_halt_opd;

  rec_t exp_q[$];
  bit   mon_en = 1'b0;
  int   total = 0;
  int   bad = 0;
  rec_t e, a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, expv);
    end
  endtask

  task automatic push(input int ph, input logic [4:0] addr, input bit rd, input bit wr,
                      input bit oe, input bit ld, input logic [2:0] opc, input bit hlt);
    rec_t r;
    r.ph = 3'(ph); r.addr = addr; r.rd = rd; r.wr = wr; r.oe = oe; r.ld = ld;
    r.opc = opc; r.hlt = hlt;
    exp_q.push_back(r);
  endtask

  // Expected 8 cycles of one instruction slot given the ac_zero level during it.
  task automatic model_slot(input bit az);
    logic [7:0] ir;
    logic [2:0] op;
    logic [4:0] opd;
    bit         alu, sto;
    if (ref_halted) begin
      repeat (8) push(4, ref_halt_opd, 0, 0, 0, 0, OP_HLT, 1);
      return;
    end
    ir  = ref_mem[ref_pc];
    op  = ir[7:5];
    opd = ir[4:0];
    push(0, ref_pc, 0, 0, 0, 0, ref_prev_op, 0);
    push(1, ref_pc, 1, 0, 0, 0, ref_prev_op, 0);
    push(2, ref_pc, 1, 0, 0, 0, ref_prev_op, 0);
    push(3, ref_pc, 1, 0, 0, 0, op, 0);
    if (op == OP_HLT) begin
      repeat (4) push(4, opd, 0, 0, 0, 0, op, 1);
      ref_halted   = 1'b1;
      ref_halt_opd = opd;
      return;
    end
    alu = (op >= 3'd2) && (op <= 3'd5);
    sto = (op == OP_STO);
    push(4, opd, 0, 0, 0, 0, op, 0);
    push(5, opd, alu, 0, 0, 0, op, 0);
    push(6, opd, alu, 0, sto, 0, op, 0);
    push(7, opd, alu, sto, sto, alu, op, 0);
    if (sto) ref_mem[opd] = acc_val;
    if (op == OP_JMP) ref_pc = opd;
    else ref_pc = 5'(ref_pc + 5'd1 + ((op == OP_SKZ && az) ? 5'd1 : 5'd0));
    ref_prev_op = op;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({mem_addr, mem_rd, mem_wr, data_oe, ld_ac, opcode, phase, halt});
  endfunction

  // Assert reset, preload memory, check reset outputs, release reset at posedge+2.
  task automatic load_and_start(input mem_t img);
    @(posedge clk); #1;
    rst = 1'b1;
    load_img = img;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    check("reset_outputs", all_outs(), 32'd0);
    ref_mem = img; ref_pc = '0; ref_halted = 1'b0; ref_prev_op = '0; ref_halt_opd = '0;
    rst = 1'b0;
  endtask

  // mode 0: ac_zero=0, 1: ac_zero=1, 2: random per instruction.
  task automatic run_slots(input int n, input int mode);
    for (int s = 0; s < n; s++) begin
      ac_zero = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
      model_slot(ac_zero);
      mon_en = 1'b1;
      repeat (8) @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < 32; i++) if (env_mem[i] !== ref_mem[i]) diffs++;
    check(name, 32'(diffs), 32'd0);
  endtask

  initial begin
    mem_t img;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (mon_en) begin
            if (exp_q.size() == 0) begin
              check("queue_empty", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              a = {phase, mem_addr, mem_rd, mem_wr, data_oe, ld_ac, opcode, halt};
              check("cycle", 32'(a), 32'(e));
            end
          end
        end
      end
      begin : stimulus
        // Directed: LDA/ADD/STO/SKZ/JMP to 0x1F then wrap to 0x00.
        for (int az = 0; az < 2; az++) begin
          for (int i = 0; i < 32; i++) img[i] = 8'h40 | 8'(i);
          img[0] = 8'hBA; img[1] = 8'h45; img[2] = 8'hD0; img[3] = 8'h20;
          img[4] = 8'hFF; img[5] = 8'hFF; img[31] = 8'h81; img[16] = 8'h33;
          acc_val = 8'hC3;
          load_and_start(img);
          run_slots(9, az);
          check_mem("sto_mem");
        end
        // Directed: HLT at address 2, hold > 20 cycles, then reset restarts at pc 0.
        for (int i = 0; i < 32; i++) img[i] = 8'h40 | 8'(i);
        img[0] = 8'hBA; img[1] = 8'h45; img[2] = 8'h07;
        load_and_start(img);
        run_slots(6, 2);
        check("halt_held", 32'({halt, phase}), 32'({1'b1, 3'd4}));
        rst = 1'b1; #1;
        check("halt_reset", all_outs(), 32'd0);
        rst = 1'b0;
        ref_pc = '0; ref_halted = 1'b0; ref_prev_op = '0;
        run_slots(2, 2);
        // Randomized programs, HLT kept rare.
        for (int p = 0; p < 6; p++) begin
          for (int i = 0; i < 32; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 31) == 0) op = OP_HLT;
            img[i] = {op, 5'($urandom_range(0, 31))};
          end
          acc_val = 8'($urandom);
          load_and_start(img);
          run_slots(30, 2);
          check_mem("rand_mem");
        end
        // Reset during ALU_OP of STO: immediate zero outputs, no write.
        for (int i = 0; i < 32; i++) img[i] = 8'h40 | 8'(i);
        img[0] = 8'hD0; img[16] = 8'h5A;
        acc_val = 8'hA5;
        load_and_start(img);
        repeat (6) @(posedge clk);
        #2;
        check("sto_ph6", 32'({phase, data_oe, mem_wr}), 32'({3'd6, 1'b1, 1'b0}));
        rst = 1'b1; #1;
        check("abort_outputs", all_outs(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", 32'(wr_count), 32'd0);
        check("abort_mem", 32'(env_mem[16]), 32'h5A);
`ifdef SINGLE_STEP_EN
        step = 1'b0;
        load_and_start(img);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("step_hold", 32'(phase), 32'd0);
        end
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        for (int k = 1; k <= 10; k++) begin
          @(negedge clk);
          check("step_run", 32'(phase), (k <= 7) ? 32'(k) : 32'd0);
          @(posedge clk); #1;
        end
        step = 1'b1;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_any
  end

endmodule
